// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the IF-ID-EX-EC-WB pipeline; tracks one outstanding inst and data bus transaction.
// Segment controls are combinational from inputs and state; divider and bus FSMs update on the next clock.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic inst_addr_ok,
  input  logic inst_data_ok,
  output logic inst_req_en,
  input  logic ex_data_req,
  input  logic data_addr_ok,
  input  logic data_data_ok,
  output logic data_req_en,
  input  logic load_use,
  input  logic div_start,
  input  logic exc_commit,
  output logic pc_stall,
  output logic if_id_stall,
  output logic if_id_refresh,
  output logic id_ex_stall,
  output logic id_ex_refresh,
  output logic ex_ec_stall,
  output logic ex_ec_refresh,
  output logic ec_wb_stall,
  output logic ec_wb_refresh,
  output logic data_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} bus_st_e;

  bus_st_e          d_st_q, d_st_d;
  bus_st_e          i_st_q, i_st_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  logic flush, div_busy, s_ec, s_ex_other, s_ex, s_id, s_if, i_drop;

  // Hazards and flush are masked while in reset so every control reads as idle.
  always_comb begin
    flush      = exc_commit & resetn;
    div_busy   = div_start & (div_cnt_q != CNT_W'(1));
    s_ec       = resetn & (d_st_q == ST_WAIT) & ~data_data_ok;
    s_ex_other = resetn & ((ex_data_req & ~(data_req_en & data_addr_ok)) | div_busy);
    s_ex       = s_ec | s_ex_other;
    s_id       = s_ex | (resetn & load_use);
    s_if       = s_id | (resetn & ((inst_req & ~(inst_req_en & inst_addr_ok))
                                 | ((i_st_q == ST_WAIT) & ~inst_data_ok)
                                 | (i_st_q == ST_DRAIN)));
    i_drop     = resetn & (i_st_q == ST_DRAIN) & inst_data_ok;
  end

  // Data channel FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) d_st_q <= ST_IDLE;
    else         d_st_q <= d_st_d;
  end

  always_comb begin
    d_st_d = d_st_q;
    case (d_st_q)
      ST_IDLE:  if (ex_data_req & data_addr_ok & ~s_ex_other) d_st_d = ST_WAIT;
      ST_WAIT:  if (data_data_ok) d_st_d = ST_IDLE;
                else if (exc_commit) d_st_d = ST_DRAIN;
      ST_DRAIN: if (data_data_ok) d_st_d = ST_IDLE;
      default:  d_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_req_en = (d_st_q == ST_IDLE);
    data_busy   = (d_st_q != ST_IDLE);
  end

  // Instruction channel FSM; an accepted fetch is always tracked since the bus has taken it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) i_st_q <= ST_IDLE;
    else         i_st_q <= i_st_d;
  end

  always_comb begin
    i_st_d = i_st_q;
    case (i_st_q)
      ST_IDLE:  if (inst_req & inst_addr_ok) i_st_d = ST_WAIT;
      ST_WAIT:  if (inst_data_ok) i_st_d = ST_IDLE;
                else if (exc_commit) i_st_d = ST_DRAIN;
      ST_DRAIN: if (inst_data_ok) i_st_d = ST_IDLE;
      default:  i_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inst_req_en = (i_st_q == ST_IDLE);
  end

  // Divider counter: the last count is held while EC stalls so the divide stays in EX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div_cnt_q <= '0;
    else         div_cnt_q <= div_cnt_d;
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (exc_commit) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == '0) begin
      if (div_start) div_cnt_d = CNT_W'(DIV_CYCLES - 1);
    end else if (div_cnt_q != CNT_W'(1)) begin
      div_cnt_d = div_cnt_q - CNT_W'(1);
    end else if (!s_ec) begin
      div_cnt_d = '0;
    end
  end

  // Refresh wins over stall in every segment.
  always_comb begin
    if_id_refresh = flush | (s_if & ~s_id) | i_drop;
    id_ex_refresh = flush | (s_id & ~s_ex);
    ex_ec_refresh = flush | (s_ex & ~s_ec);
    ec_wb_refresh = flush | s_ec;
    pc_stall      = s_if;
    if_id_stall   = s_id & ~if_id_refresh;
    id_ex_stall   = s_ex & ~id_ex_refresh;
    ex_ec_stall   = s_ec & ~ex_ec_refresh;
    ec_wb_stall   = 1'b0;
  end

endmodule
